// File: rtl/buffered_uart_tx.sv
// ============================================================================
// Module   : buffered_uart_tx
// Purpose  : 8N1/8N2 serial transmitter fed by a ready/enable byte handshake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module buffered_uart_tx #(
    parameter int DIV_W     = 16,
    parameter int STOP_BITS = 1
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [7:0]       uart_value,
    input  logic             uart_enable,
    input  logic [DIV_W-1:0] uart_divider,
    output logic             uart_ready,
    output logic             tx_o,
    output logic             busy_o
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    localparam logic c_STOP_LAST = 1'(STOP_BITS - 1);

    logic [1:0]       r_state;
    logic [7:0]       r_shift;
    logic [DIV_W-1:0] r_period;
    logic [DIV_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic             r_stop;
    logic             r_tx;
    logic             r_ready;
    logic             r_busy;

    logic [DIV_W-1:0] w_div_eff;
    logic             w_accept;
    logic             w_bit_end;

    // A zero divider would otherwise load an all-ones count and stall the bit.
    assign w_div_eff = (uart_divider == '0) ? DIV_W'(1) : uart_divider;
    assign w_accept  = r_ready && uart_enable;
    assign w_bit_end = (r_cnt == '0);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state  <= c_IDLE;
            r_shift  <= '0;
            r_period <= '0;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_stop   <= 1'b0;
            r_tx     <= 1'b1;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_shift  <= uart_value;
                        r_period <= w_div_eff;
                        r_cnt    <= w_div_eff - DIV_W'(1);
                        r_tx     <= 1'b0;
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= c_START;
                    end
                end
                c_START: begin
                    if (w_bit_end) begin
                        r_cnt   <= r_period - DIV_W'(1);
                        r_tx    <= r_shift[0];
                        r_shift <= {1'b0, r_shift[7:1]};
                        r_bit   <= '0;
                        r_state <= c_DATA;
                    end else begin
                        r_cnt <= r_cnt - DIV_W'(1);
                    end
                end
                c_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= r_period - DIV_W'(1);
                        if (r_bit == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_stop  <= 1'b0;
                            r_state <= c_STOP;
                        end else begin
                            r_tx    <= r_shift[0];
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_bit   <= r_bit + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - DIV_W'(1);
                    end
                end
                c_STOP: begin
                    if (w_bit_end) begin
                        if (r_stop == c_STOP_LAST) begin
                            r_ready <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= c_IDLE;
                        end else begin
                            r_stop <= 1'b1;
                            r_cnt  <= r_period - DIV_W'(1);
                        end
                    end else begin
                        r_cnt <= r_cnt - DIV_W'(1);
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign uart_ready = r_ready;
    assign tx_o       = r_tx;
    assign busy_o     = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_buffered_uart_tx.sv
// ============================================================================
// Module   : tb_buffered_uart_tx
// Purpose  : Directed scoreboard bench for buffered_uart_tx (1 and 2 stop bits).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_buffered_uart_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  value;
    logic        en1, en2;
    logic [15:0] divider;
    logic        ready1, tx1, busy1;
    logic        ready2, tx2, busy2;

    int n_assert = 0;
    int n_fail   = 0;
    logic q[$];

    always #5 clk = ~clk;

    buffered_uart_tx #(.DIV_W(16), .STOP_BITS(1)) dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst), .uart_value(value), .uart_enable(en1),
        .uart_divider(divider), .uart_ready(ready1), .tx_o(tx1), .busy_o(busy1)
    );

    buffered_uart_tx #(.DIV_W(16), .STOP_BITS(2)) dut2 (
        .wb_clk_i(clk), .wb_rst_i(rst), .uart_value(value), .uart_enable(en2),
        .uart_divider(divider), .uart_ready(ready2), .tx_o(tx2), .busy_o(busy2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Expected line level for every cycle of one frame.
    task automatic push_frame(input logic [7:0] v, input int div, input int stops);
        int d;
        d = (div == 0) ? 1 : div;
        for (int i = 0; i < d; i++) q.push_back(1'b0);
        for (int b = 0; b < 8; b++)
            for (int i = 0; i < d; i++) q.push_back(v[b]);
        for (int i = 0; i < stops * d; i++) q.push_back(1'b1);
    endtask

    task automatic send(input bit sel, input logic [7:0] v, input int div, input int stops);
        value   = v;
        divider = 16'(div);
        if (sel) en2 = 1'b1; else en1 = 1'b1;
        push_frame(v, div, stops);
        step();
        en1 = 1'b0;
        en2 = 1'b0;
    endtask

    task automatic drain(input bit sel, input int pulse_at, input int abort_at);
        int   i;
        logic e;
        i = 0;
        while (q.size() > 0) begin
            if (i == abort_at) return;
            e = q.pop_front();
            chk("tx", sel ? tx2 : tx1, e);
            chk("ready_low", sel ? ready2 : ready1, 1'b0);
            chk("busy_high", sel ? busy2 : busy1, 1'b1);
            if (pulse_at >= 0 && i == pulse_at) begin
                value   = 8'hFF;
                divider = 16'd10;
                en1     = 1'b1;
            end else if (pulse_at >= 0 && i == pulse_at + 1) begin
                en1 = 1'b0;
            end
            step();
            i++;
        end
        chk("ready_after", sel ? ready2 : ready1, 1'b1);
        chk("busy_after", sel ? busy2 : busy1, 1'b0);
        chk("tx_after", sel ? tx2 : tx1, 1'b1);
    endtask

    initial begin
        rst = 1'b1; en1 = 1'b0; en2 = 1'b0; value = 8'h00; divider = 16'd4;
        step(); step();
        chk("rst_tx1", tx1, 1'b1);
        chk("rst_ready1", ready1, 1'b1);
        chk("rst_busy1", busy1, 1'b0);
        chk("rst_tx2", tx2, 1'b1);
        chk("rst_ready2", ready2, 1'b1);
        rst = 1'b0;
        step();

        // Divider 4, 0xA5: 40-cycle frame
        send(1'b0, 8'hA5, 4, 1);
        drain(1'b0, -1, -1);
        step();

        // Divider 0 and 1 must both give 1 clock per bit
        send(1'b0, 8'h3C, 0, 1);
        drain(1'b0, -1, -1);
        step();
        send(1'b0, 8'h3C, 1, 1);
        drain(1'b0, -1, -1);
        step();

        // Mid-frame enable/value/divider changes are ignored
        send(1'b0, 8'h55, 3, 1);
        drain(1'b0, 5, -1);
        for (int i = 0; i < 15; i++) begin
            step();
            chk("no_ff_tx", tx1, 1'b1);
            chk("no_ff_ready", ready1, 1'b1);
        end

        // Back-to-back with enable held: one idle-high cycle between frames
        value = 8'h00; divider = 16'd2; en1 = 1'b1;
        push_frame(8'h00, 2, 1);
        step();
        value = 8'hFF;
        drain(1'b0, -1, -1);
        push_frame(8'hFF, 2, 1);
        step();
        en1 = 1'b0;
        drain(1'b0, -1, -1);
        step();

        // Reset during data bit 3 of 0x81, enable ignored while in reset
        send(1'b0, 8'h81, 2, 1);
        drain(1'b0, -1, 9);
        q.delete();
        rst = 1'b1; en1 = 1'b1;
        step();
        rst = 1'b0; en1 = 1'b0;
        chk("midrst_tx", tx1, 1'b1);
        chk("midrst_ready", ready1, 1'b1);
        chk("midrst_busy", busy1, 1'b0);
        step();
        chk("postrst_tx", tx1, 1'b1);
        chk("postrst_ready", ready1, 1'b1);
        send(1'b0, 8'h12, 2, 1);
        drain(1'b0, -1, -1);
        step();

        // Two stop bits, divider 5, 0xF0: 55-cycle frame
        send(1'b1, 8'hF0, 5, 2);
        drain(1'b1, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
